// File: rtl/lsu_pkg.sv
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types and defaults for the lsu_ctrl load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_READ  = 2'b01,
      ST_WRITE = 2'b10,
      ST_RESP  = 2'b11
   } state_e;

   localparam int LSU_DEPTH = 128;

   // True when the low address bits do not match the natural alignment of size.
   function automatic logic misaligned(input size_e size, input logic [1:0] lo);
      case (size)
         SZ_HALF: misaligned = lo[0];
         SZ_WORD: misaligned = |lo;
         default: misaligned = 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
// Module  : lsu_lane
// Brief   : Lane extract/extend for loads and lane merge for sub-word stores.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
   import lsu_pkg::*;
(
   input  logic        size_unused_i,
   input  size_e       size_i,
   input  logic [1:0]  lane_i,
   input  logic        unsigned_i,
   input  logic [31:0] rdata_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = rdata_i[{lane_i, 3'b000} +: 8];
   assign w_half = rdata_i[{lane_i[1], 4'b0000} +: 16];

   always_comb begin
      load_o  = 32'h0;
      merge_o = rdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o = unsigned_i ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            // Only addr[1] picks the half; addr[0] is either faulted or ignored upstream.
            load_o = unsigned_i ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         SZ_WORD: begin
            load_o  = rdata_i;
            merge_o = wdata_i;
         end
         default: begin
            load_o  = 32'h0;
            merge_o = rdata_i;
         end
      endcase
   end

   logic w_unused;
   assign w_unused = size_unused_i;

endmodule

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module  : lsu_ctrl
// Brief   : Load/store unit: byte address to word index, sub-word RMW stores,
//           sign/zero-extended loads. Define LSU_ALIGN_CHECK_EN to fault on
//           misaligned half/word accesses instead of forcing natural alignment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int DEPTH  = LSU_DEPTH,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   state_e      state_q, state_d;
   logic        we_q, we_d;
   size_e       size_q, size_d;
   logic        uns_q, uns_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] maddr_q, maddr_d;
   logic [31:0] mwdata_q, mwdata_d;

   size_e             w_req_size;
   logic [ADDR_W-1:0] w_idx;
   logic [31:0]       w_idx32;
   logic              w_misalign;
   logic              w_fault;
   logic [31:0]       w_load;
   logic [31:0]       w_merge;

   assign w_req_size = size_e'(req_size);
   assign w_idx      = req_addr >> 2;
   assign w_idx32    = 32'(w_idx);

`ifdef LSU_ALIGN_CHECK_EN
   assign w_misalign = misaligned(w_req_size, req_addr[1:0]);
`else
   assign w_misalign = 1'b0;
`endif

   assign w_fault = (w_req_size == SZ_RSVD) || (w_idx >= ADDR_W'(DEPTH)) || w_misalign;

   lsu_lane u_lane (
      .size_unused_i (1'b0),
      .size_i        (size_q),
      .lane_i        (lane_q),
      .unsigned_i    (uns_q),
      .rdata_i       (mem_rdata),
      .wdata_i       (wdata_q),
      .load_o        (w_load),
      .merge_o       (w_merge)
   );

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      lane_d     = lane_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      maddr_d    = maddr_q;
      mwdata_d   = mwdata_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = w_req_size;
               uns_d   = req_unsigned;
               lane_d  = req_addr[1:0];
               wdata_d = req_wdata;
               rdata_d = 32'h0;
               err_d   = 1'b0;
               if (w_fault) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  maddr_d = w_idx32;
                  if (req_we && (w_req_size == SZ_WORD)) begin
                     mwdata_d = req_wdata;
                     state_d  = ST_WRITE;
                  end else begin
                     state_d = ST_READ;
                  end
               end
            end
         end
         ST_READ: begin
            if (we_q) begin
               mwdata_d = w_merge;
               state_d  = ST_WRITE;
            end else begin
               rdata_d = w_load;
               state_d = ST_RESP;
            end
         end
         ST_WRITE: begin
            mem_we  = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // The address leaves combinationally on accept so the synchronous memory
   // returns data during READ; afterwards it is held from the register.
   assign mem_addr   = maddr_d;
   assign mem_wdata  = mwdata_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         we_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         uns_q    <= 1'b0;
         lane_q   <= 2'b00;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
         maddr_q  <= 32'h0;
         mwdata_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         lane_q   <= lane_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         maddr_q  <= maddr_d;
         mwdata_q <= mwdata_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// ============================================================================
// Module  : tb_lsu_ctrl
// Brief   : Directed self-checking bench for lsu_ctrl with a word memory model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_ctrl;

   localparam logic [1:0] SB = 2'b00;
   localparam logic [1:0] SH = 2'b01;
   localparam logic [1:0] SW = 2'b10;
   localparam logic [1:0] SR = 2'b11;

   logic        clk;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:127];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          we_cnt   = 0;
   logic [31:0] last_widx  = 32'h0;
   logic [31:0] last_wdata = 32'h0;

   lsu_ctrl dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous word memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr[6:0]] <= mem_wdata;
         we_cnt     <= we_cnt + 1;
         last_widx  <= mem_addr;
         last_wdata <= mem_wdata;
      end
      mem_rdata <= mem[mem_addr[6:0]];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge in IDLE, wait for the response and check it.
   task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err);
      int lat;
      check({tag, " ready"}, 32'(req_ready), 32'h1);
      req_we       = we;
      req_size     = sz;
      req_unsigned = un;
      req_addr     = addr;
      req_wdata    = wd;
      req_valid    = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      check({tag, " latency"}, 32'(lat), 32'(exp_lat));
      check({tag, " rdata"}, resp_rdata, exp_data);
      check({tag, " err"}, 32'(resp_err), 32'(exp_err));
      @(negedge clk);
   endtask

   initial begin : stim
      int n0;
      int lat;
      int acc;
      int rsp;

      reset_n      = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = SB;
      req_unsigned = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      resp_ready   = 1'b1;
      repeat (2) @(negedge clk);
      check("rst resp_valid", 32'(resp_valid), 32'h0);
      check("rst resp_rdata", resp_rdata, 32'h0);
      check("rst resp_err", 32'(resp_err), 32'h0);
      check("rst mem_we", 32'(mem_we), 32'h0);
      check("rst mem_addr", mem_addr, 32'h0);
      check("rst mem_wdata", mem_wdata, 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst req_ready", 32'(req_ready), 32'h1);

      // Word store and load back
      n0 = we_cnt;
      do_req("sw 0x10", 1'b1, SW, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0);
      check("sw 0x10 we pulses", 32'(we_cnt - n0), 32'h1);
      check("sw 0x10 widx", last_widx, 32'h4);
      check("sw 0x10 wdata", last_wdata, 32'hDEADBEEF);
      do_req("lw 0x10", 1'b0, SW, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);

      // Byte RMW and byte extension
      do_req("sw 0x20", 1'b1, SW, 1'b0, 32'h20, 32'h11223344, 2, 32'h0, 1'b0);
      n0 = we_cnt;
      do_req("sb 0x22", 1'b1, SB, 1'b0, 32'h22, 32'h123456AA, 3, 32'h0, 1'b0);
      check("sb 0x22 we pulses", 32'(we_cnt - n0), 32'h1);
      check("sb 0x22 widx", last_widx, 32'h8);
      check("sb 0x22 merged", last_wdata, 32'h11AA3344);
      do_req("lb 0x22", 1'b0, SB, 1'b0, 32'h22, 32'h0, 2, 32'hFFFFFFAA, 1'b0);
      do_req("lbu 0x22", 1'b0, SB, 1'b1, 32'h22, 32'h0, 2, 32'h000000AA, 1'b0);

      // Misaligned half load
      n0 = we_cnt;
`ifdef LSU_ALIGN_CHECK_EN
      do_req("lh 0x21", 1'b0, SH, 1'b0, 32'h21, 32'h0, 1, 32'h0, 1'b1);
      check("lh 0x21 addr held", mem_addr, 32'h8);
`else
      do_req("lh 0x21", 1'b0, SH, 1'b0, 32'h21, 32'h0, 2, 32'h00003344, 1'b0);
`endif
      check("lh 0x21 no write", 32'(we_cnt - n0), 32'h0);

      // Extension boundaries
      do_req("sw 0x30", 1'b1, SW, 1'b0, 32'h30, 32'h80007F80, 2, 32'h0, 1'b0);
      do_req("lb 0x30", 1'b0, SB, 1'b0, 32'h30, 32'h0, 2, 32'hFFFFFF80, 1'b0);
      do_req("lbu 0x30", 1'b0, SB, 1'b1, 32'h30, 32'h0, 2, 32'h00000080, 1'b0);
      do_req("lh 0x32", 1'b0, SH, 1'b0, 32'h32, 32'h0, 2, 32'hFFFF8000, 1'b0);
      do_req("lhu 0x32", 1'b0, SH, 1'b1, 32'h32, 32'h0, 2, 32'h00008000, 1'b0);
      do_req("lb 0x33", 1'b0, SB, 1'b0, 32'h33, 32'h0, 2, 32'hFFFFFF80, 1'b0);
      do_req("lh 0x30", 1'b0, SH, 1'b0, 32'h30, 32'h0, 2, 32'h00007F80, 1'b0);

      // Half RMW in the upper lane
      do_req("sh 0x32", 1'b1, SH, 1'b0, 32'h32, 32'h1234BEEF, 3, 32'h0, 1'b0);
      check("sh 0x32 merged", last_wdata, 32'hBEEF7F80);

      // Faults: out of range and reserved size
      n0 = we_cnt;
      do_req("lw 4*DEPTH", 1'b0, SW, 1'b0, 32'h200, 32'h0, 1, 32'h0, 1'b1);
      do_req("sw rsvd", 1'b1, SR, 1'b0, 32'h10, 32'h55555555, 1, 32'h0, 1'b1);
      do_req("sb 4*DEPTH", 1'b1, SB, 1'b0, 32'h200, 32'h77, 1, 32'h0, 1'b1);
      check("fault no write", 32'(we_cnt - n0), 32'h0);
      check("fault addr held", mem_addr, 32'hC);

      // Misaligned word store
`ifdef LSU_ALIGN_CHECK_EN
      do_req("sw 0x13", 1'b1, SW, 1'b0, 32'h13, 32'hCAFEF00D, 1, 32'h0, 1'b1);
      do_req("lw 0x10 after", 1'b0, SW, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
`else
      do_req("sw 0x13", 1'b1, SW, 1'b0, 32'h13, 32'hCAFEF00D, 2, 32'h0, 1'b0);
      do_req("lw 0x10 after", 1'b0, SW, 1'b0, 32'h10, 32'h0, 2, 32'hCAFEF00D, 1'b0);
`endif

      // Response backpressure
      resp_ready   = 1'b0;
      req_we       = 1'b0;
      req_size     = SW;
      req_unsigned = 1'b0;
      req_addr     = 32'h20;
      req_valid    = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0;
      while (lat < 10) begin
         @(negedge clk);
         lat++;
         if (resp_valid) break;
      end
      check("hold latency", 32'(lat), 32'h2);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold resp_valid", 32'(resp_valid), 32'h1);
         check("hold rdata", resp_rdata, 32'h11AA3344);
         check("hold req_ready", 32'(req_ready), 32'h0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("release resp_valid", 32'(resp_valid), 32'h0);
      check("release req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);

      // Back-to-back loads with resp_ready high: one every three cycles
      req_we    = 1'b0;
      req_size  = SW;
      req_addr  = 32'h20;
      req_valid = 1'b1;
      acc = 0;
      rsp = 0;
      for (int i = 0; i < 9; i++) begin
         if (req_ready) acc++;
         if (resp_valid) begin
            rsp++;
            check("b2b rdata", resp_rdata, 32'h11AA3344);
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b accepts", 32'(acc), 32'h3);
      check("b2b responses", 32'(rsp), 32'h3);
      @(negedge clk);

      // Reset in the WRITE phase of a byte RMW
      req_we    = 1'b1;
      req_size  = SB;
      req_addr  = 32'h31;
      req_wdata = 32'h55;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rmw in write", 32'(mem_we), 32'h1);
      n0 = we_cnt;
      #2 reset_n = 1'b0;
      #1;
      check("arst mem_we", 32'(mem_we), 32'h0);
      check("arst resp_valid", 32'(resp_valid), 32'h0);
      check("arst resp_rdata", resp_rdata, 32'h0);
      check("arst resp_err", 32'(resp_err), 32'h0);
      check("arst mem_addr", mem_addr, 32'h0);
      check("arst mem_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      check("arst no write", 32'(we_cnt - n0), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check("arst req_ready", 32'(req_ready), 32'h1);
      do_req("lw 0x30 after rst", 1'b0, SW, 1'b0, 32'h30, 32'h0, 2, 32'hBEEF7F80, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
